// File: rtl/rx_ber_checker.sv
// PRBS-15 bit-error-rate checker for a demodulated AXI-Stream frame feed.
// Three-stage pipeline: beat capture, masked error vector, popcount/frame commit.
module rx_ber_checker #(
   parameter int          WIDTH_AXI_DATA = 32,
   parameter int          LENGTH_DATA    = 1024,
   parameter int          PAM_ORDER      = 4,
   parameter logic [14:0] PRBS_SEED      = 15'h7FFF,
   parameter int          CNT_WIDTH      = 32
) (
   input  logic                          clk,
   input  logic                          arst_n,
   input  logic                          s_axi_tvalid,
   output logic                          s_axi_tready,
   input  logic [WIDTH_AXI_DATA-1:0]     s_axi_tdata,
   input  logic [WIDTH_AXI_DATA/8-1:0]   s_axi_tkeep,
   input  logic                          s_axi_tlast,
   input  logic                          clear,
   output logic [CNT_WIDTH-1:0]          frame_cnt,
   output logic [CNT_WIDTH-1:0]          bit_err_cnt,
   output logic [CNT_WIDTH-1:0]          err_frame_cnt,
   output logic [CNT_WIDTH-1:0]          len_err_cnt,
   output logic [CNT_WIDTH-1:0]          frame_err_bits,
   output logic                          frame_done
);
   localparam int W   = WIDTH_AXI_DATA;
   localparam int KW  = W / 8;
   localparam int BPS = $clog2(PAM_ORDER);
   localparam int WPF = LENGTH_DATA * BPS / W;
   localparam int WCW = $clog2(WPF + 1);
   localparam int PCW = $clog2(W + 1);
   localparam int FBW = $clog2(WPF * W + 1);
   localparam int ACW = (FBW > CNT_WIDTH) ? FBW : CNT_WIDTH;
   localparam logic [ACW:0] CNT_MAX_W = (ACW+1)'({CNT_WIDTH{1'b1}});

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   function automatic logic [W+14:0] prbs_word(input logic [14:0] s_in);
      logic [14:0]  s;
      logic [W-1:0] w;
      s = s_in;
      w = '0;
      for (int i = 0; i < W; i++) begin
         w[i] = s[14];
         s    = {s[13:0], s[14] ^ s[13]};
      end
      return {s, w};
   endfunction

   function automatic logic [PCW-1:0] popcount(input logic [W-1:0] v);
      logic [PCW-1:0] c;
      c = '0;
      for (int i = 0; i < W; i++) c = c + PCW'(v[i]);
      return c;
   endfunction

   function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [ACW:0] v);
      if (v > CNT_MAX_W) return {CNT_WIDTH{1'b1}};
      else               return v[CNT_WIDTH-1:0];
   endfunction

   function automatic logic [CNT_WIDTH-1:0] inc_sat(input logic [CNT_WIDTH-1:0] c);
      if (&c) return c;
      else    return c + CNT_WIDTH'(1);
   endfunction

   state_t              state_q;
   logic [WCW-1:0]      wcnt_q;
   logic [14:0]         prbs_q, prbs_d;
   logic                tready_q;
   logic                s0_vld_q, s0_last_q, s0_lerr_q;
   logic [W-1:0]        s0_data_q, s0_ref_q;
   logic [KW-1:0]       s0_keep_q;
   logic [W-1:0]        err_vec_q;
   logic                s1_last_q, s1_lerr_q;
   logic [ACW-1:0]      acc_q, acc_d;
   logic                acc_lerr_q;
   logic [CNT_WIDTH-1:0] frame_cnt_q, bit_err_cnt_q, err_frame_cnt_q, len_err_cnt_q, frame_err_bits_q;
   logic                frame_done_q;

   logic [W-1:0]        ref_word_s, keep_mask_s;
   logic                beat_s, over_s, len_bad_s, lerr_beat_s, frame_lerr_s;
   logic [PCW-1:0]      pop_s;
   logic [ACW:0]        acc_sum_s, bit_sum_s;

   assign beat_s                 = s_axi_tvalid & tready_q;
   assign {prbs_d, ref_word_s}   = prbs_word(prbs_q);
   // wcnt is zero in IDLE, so the same length test serves both states
   assign over_s      = (wcnt_q >= WCW'(WPF));
   assign len_bad_s   = (({1'b0, wcnt_q} + (WCW+1)'(1)) != (WCW+1)'(WPF));
   assign lerr_beat_s = over_s | (s_axi_tlast & len_bad_s);

   assign pop_s        = popcount(err_vec_q);
   assign acc_sum_s    = {1'b0, acc_q} + (ACW+1)'(pop_s);
   assign acc_d        = acc_sum_s[ACW] ? {ACW{1'b1}} : acc_sum_s[ACW-1:0];
   assign frame_lerr_s = acc_lerr_q | s1_lerr_q;
   assign bit_sum_s    = (ACW+1)'(bit_err_cnt_q) + (ACW+1)'(acc_d);

   // byte enables expanded to a bit mask for the captured beat
   always_comb begin
      keep_mask_s = '0;
      for (int j = 0; j < KW; j++) keep_mask_s[8*j +: 8] = {8{s0_keep_q[j]}};
   end

   // frame FSM, reference PRBS and beat capture
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= IDLE;
         wcnt_q    <= '0;
         prbs_q    <= PRBS_SEED;
         tready_q  <= 1'b0;
         s0_vld_q  <= 1'b0;
         s0_last_q <= 1'b0;
         s0_lerr_q <= 1'b0;
         s0_data_q <= '0;
         s0_ref_q  <= '0;
         s0_keep_q <= '0;
      end else begin
         tready_q  <= 1'b1;
         s0_vld_q  <= beat_s;
         s0_last_q <= beat_s & s_axi_tlast;
         s0_lerr_q <= beat_s & lerr_beat_s;
         s0_data_q <= s_axi_tdata;
         s0_ref_q  <= ref_word_s;
         s0_keep_q <= s_axi_tkeep;
         if (beat_s) begin
            prbs_q <= s_axi_tlast ? PRBS_SEED : prbs_d;
            case (state_q)
               IDLE: begin
                  if (s_axi_tlast) begin
                     state_q <= IDLE;
                     wcnt_q  <= '0;
                  end else begin
                     state_q <= RUN;
                     wcnt_q  <= WCW'(1);
                  end
               end
               RUN: begin
                  if (s_axi_tlast) begin
                     state_q <= IDLE;
                     wcnt_q  <= '0;
                  end else begin
                     state_q <= RUN;
                     wcnt_q  <= over_s ? wcnt_q : wcnt_q + WCW'(1);
                  end
               end
               default: begin
                  state_q <= IDLE;
                  wcnt_q  <= '0;
               end
            endcase
         end
      end
   end

   // masked error vector
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         err_vec_q <= '0;
         s1_last_q <= 1'b0;
         s1_lerr_q <= 1'b0;
      end else begin
         err_vec_q <= s0_vld_q ? ((s0_data_q ^ s0_ref_q) & keep_mask_s) : '0;
         s1_last_q <= s0_last_q;
         s1_lerr_q <= s0_lerr_q;
      end
   end

   // frame accumulation and statistics commit; clear beats a same-cycle commit
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         acc_q            <= '0;
         acc_lerr_q       <= 1'b0;
         frame_done_q     <= 1'b0;
         frame_cnt_q      <= '0;
         bit_err_cnt_q    <= '0;
         err_frame_cnt_q  <= '0;
         len_err_cnt_q    <= '0;
         frame_err_bits_q <= '0;
      end else begin
         frame_done_q <= s1_last_q;
         if (s1_last_q) begin
            acc_q      <= '0;
            acc_lerr_q <= 1'b0;
         end else begin
            acc_q      <= acc_d;
            acc_lerr_q <= frame_lerr_s;
         end
         if (clear) begin
            frame_cnt_q      <= '0;
            bit_err_cnt_q    <= '0;
            err_frame_cnt_q  <= '0;
            len_err_cnt_q    <= '0;
            frame_err_bits_q <= '0;
         end else if (s1_last_q) begin
            frame_cnt_q      <= inc_sat(frame_cnt_q);
            bit_err_cnt_q    <= sat_cnt(bit_sum_s);
            frame_err_bits_q <= sat_cnt((ACW+1)'(acc_d));
            if (acc_d != '0)  err_frame_cnt_q <= inc_sat(err_frame_cnt_q);
            if (frame_lerr_s) len_err_cnt_q   <= inc_sat(len_err_cnt_q);
         end
      end
   end

   assign s_axi_tready   = tready_q;
   assign frame_cnt      = frame_cnt_q;
   assign bit_err_cnt    = bit_err_cnt_q;
   assign err_frame_cnt  = err_frame_cnt_q;
   assign len_err_cnt    = len_err_cnt_q;
   assign frame_err_bits = frame_err_bits_q;
   assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_rx_ber_checker.sv
// Bench for rx_ber_checker: reference PRBS built from the sequence recurrence,
// per-frame error model and saturating counter scoreboard.
module tb_rx_ber_checker;
   localparam int WPF = 64;
   localparam logic [63:0] MAXC = 64'h0000_0000_FFFF_FFFF;

   typedef logic [63:0] c5_t [5];

   logic        clk = 1'b0;
   logic        arst_n, tvalid, tlast, clear;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tready, frame_done, tready4, frame_done4;
   logic [31:0] frame_cnt, bit_err_cnt, err_frame_cnt, len_err_cnt, frame_err_bits;
   logic [3:0]  frame_cnt4, bit_err_cnt4, err_frame_cnt4, len_err_cnt4, frame_err_bits4;

   rx_ber_checker dut (
      .clk(clk), .arst_n(arst_n), .s_axi_tvalid(tvalid), .s_axi_tready(tready),
      .s_axi_tdata(tdata), .s_axi_tkeep(tkeep), .s_axi_tlast(tlast), .clear(clear),
      .frame_cnt(frame_cnt), .bit_err_cnt(bit_err_cnt), .err_frame_cnt(err_frame_cnt),
      .len_err_cnt(len_err_cnt), .frame_err_bits(frame_err_bits), .frame_done(frame_done));

   rx_ber_checker #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .arst_n(arst_n), .s_axi_tvalid(tvalid), .s_axi_tready(tready4),
      .s_axi_tdata(tdata), .s_axi_tkeep(tkeep), .s_axi_tlast(tlast), .clear(clear),
      .frame_cnt(frame_cnt4), .bit_err_cnt(bit_err_cnt4), .err_frame_cnt(err_frame_cnt4),
      .len_err_cnt(len_err_cnt4), .frame_err_bits(frame_err_bits4), .frame_done(frame_done4));

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          prbs_bits [0:4095];
   logic [31:0] fdata [0:127];
   logic [3:0]  fkeep [0:127];
   logic [63:0] exp_frame, exp_bit, exp_eframe, exp_len, exp_last;
   logic [63:0] done_q[$];
   logic [63:0] exp_q[$];
   string       cname [5] = '{"frame_cnt", "bit_err_cnt", "err_frame_cnt", "len_err_cnt", "frame_err_bits"};

   always @(negedge clk) if (arst_n === 1'b1 && frame_done === 1'b1) done_q.push_back(64'(frame_err_bits));

   // o[k] = seed[14-k] for the first 15 bits, then o[n+15] = o[n] ^ o[n+1]
   task automatic init_prbs();
      logic [14:0] seed = 15'h7FFF;
      for (int k = 0; k < 15; k++) prbs_bits[k] = seed[14-k];
      for (int n = 15; n < 4096; n++) prbs_bits[n] = prbs_bits[n-15] ^ prbs_bits[n-14];
   endtask

   function automatic logic [31:0] ref_word(input int k);
      logic [31:0] w;
      for (int i = 0; i < 32; i++) w[i] = prbs_bits[32*k + i];
      return w;
   endfunction

   task automatic build_clean(input int n);
      for (int k = 0; k < n; k++) begin
         fdata[k] = ref_word(k);
         fkeep[k] = 4'hF;
      end
   endtask

   function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b);
      return (a + b > MAXC) ? MAXC : a + b;
   endfunction

   function automatic c5_t get_act();
      return '{64'(frame_cnt), 64'(bit_err_cnt), 64'(err_frame_cnt), 64'(len_err_cnt), 64'(frame_err_bits)};
   endfunction

   function automatic c5_t get_exp();
      return '{exp_frame, exp_bit, exp_eframe, exp_len, exp_last};
   endfunction

   task automatic model_clear();
      exp_frame = 0; exp_bit = 0; exp_eframe = 0; exp_len = 0; exp_last = 0;
   endtask

   task automatic model_commit(input int n);
      logic [63:0] e = 0;
      for (int k = 0; k < n; k++)
         for (int i = 0; i < 32; i++)
            if (fkeep[k][i/8] && (fdata[k][i] != prbs_bits[32*k + i])) e++;
      exp_frame = sat_add(exp_frame, 64'd1);
      exp_bit   = sat_add(exp_bit, e);
      if (e != 0)   exp_eframe = sat_add(exp_eframe, 64'd1);
      if (n != WPF) exp_len    = sat_add(exp_len, 64'd1);
      exp_last = (e > MAXC) ? MAXC : e;
      exp_q.push_back(exp_last);
   endtask

   task automatic send_frame(input int n, input int gap_max, input int clear_at);
      for (int k = 0; k < n; k++) begin
         if (gap_max > 0) begin
            tvalid = 1'b0;
            repeat ($urandom_range(gap_max, 0)) begin @(posedge clk); #1; end
         end
         tvalid = 1'b1;
         tdata  = fdata[k];
         tkeep  = fkeep[k];
         tlast  = (k == n - 1);
         clear  = (k == clear_at);
         if (k == clear_at) model_clear();
         @(posedge clk); #1;
         clear = 1'b0;
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
      model_commit(n);
   endtask

   task automatic wait_frames(input int nexp);
      int c = 0;
      while (done_q.size() < nexp && c < 400) begin @(posedge clk); #1; c++; end
      repeat (4) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      tvalid = 1'b0; tlast = 1'b0; clear = 1'b0; tdata = '0; tkeep = '0;
      arst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 arst_n = 1'b1;
      @(posedge clk); #1;
      model_clear();
      done_q.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      c5_t a;
      tvalid = 1'b0; tlast = 1'b0; clear = 1'b0; tdata = '0; tkeep = '0;
      arst_n = 1'b0;
      #13;
      a = get_act();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a[i] !== 64'd0) begin n_fail++; $display("FAIL reset %s: got %0d expected 0", cname[i], a[i]); end
      end
      n_checks++;
      if (tready !== 1'b0 || frame_done !== 1'b0) begin
         n_fail++; $display("FAIL reset outputs: tready=%b frame_done=%b expected 0 0", tready, frame_done);
      end
      @(posedge clk); #1 arst_n = 1'b1;
      #2;
      n_checks++;
      if (tready !== 1'b0) begin n_fail++; $display("FAIL tready_before_edge: got %b expected 0", tready); end
      @(posedge clk); #1;
      n_checks++;
      if (tready !== 1'b1 || tready4 !== 1'b1) begin
         n_fail++; $display("FAIL tready_after_reset: got %b/%b expected 1", tready, tready4);
      end
      model_clear();
      done_q.delete();
      exp_q.delete();
   endtask

   task automatic test_clean_frame();
      c5_t a, e;
      logic [2:0] seen;
      do_reset();
      build_clean(64);
      send_frame(64, 0, -1);
      seen[0] = frame_done;
      @(posedge clk); #1; seen[1] = frame_done;
      @(posedge clk); #1; seen[2] = frame_done;
      a = get_act();
      e = get_exp();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a[i] !== e[i]) begin n_fail++; $display("FAIL clean %s: got %0d expected %0d", cname[i], a[i], e[i]); end
      end
      @(posedge clk); #1;
      n_checks++;
      if (seen !== 3'b100 || frame_done !== 1'b0) begin
         n_fail++; $display("FAIL clean_done_timing: got %b,%b expected 100,0", seen, frame_done);
      end
      repeat (4) @(posedge clk); #1;
      n_checks++;
      if (done_q.size() != 1) begin n_fail++; $display("FAIL clean_done_count: got %0d expected 1", done_q.size()); end
   endtask

   task automatic test_injected_errors();
      c5_t a, e;
      do_reset();
      build_clean(64); send_frame(64, 0, -1);
      build_clean(64); fdata[9] = fdata[9] ^ 32'h8000_0001; send_frame(64, 0, -1);
      build_clean(64); send_frame(64, 0, -1);
      wait_frames(3);
      a = get_act();
      e = get_exp();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a[i] !== e[i]) begin n_fail++; $display("FAIL inject %s: got %0d expected %0d", cname[i], a[i], e[i]); end
      end
      n_checks++;
      if (done_q.size() != 3) begin n_fail++; $display("FAIL inject_done_count: got %0d expected 3", done_q.size()); end
      else begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (done_q[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL inject_frame_err_bits[%0d]: got %0d expected %0d", i, done_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_length_errors();
      c5_t a, e;
      do_reset();
      build_clean(40); send_frame(40, 0, -1);
      build_clean(70); send_frame(70, 0, -1);
      build_clean(64); send_frame(64, 0, -1);
      build_clean(1);  send_frame(1, 0, -1);
      wait_frames(4);
      a = get_act();
      e = get_exp();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a[i] !== e[i]) begin n_fail++; $display("FAIL length %s: got %0d expected %0d", cname[i], a[i], e[i]); end
      end
   endtask

   task automatic test_tkeep();
      c5_t a, e;
      do_reset();
      build_clean(64);
      fkeep[4] = 4'b0011;
      fdata[4] = fdata[4] ^ 32'hFFFF_0000;
      send_frame(64, 0, -1);
      build_clean(64);
      fkeep[4] = 4'b0011;
      fdata[4] = fdata[4] ^ 32'h00F0_0100;
      send_frame(64, 0, -1);
      wait_frames(2);
      a = get_act();
      e = get_exp();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a[i] !== e[i]) begin n_fail++; $display("FAIL tkeep %s: got %0d expected %0d", cname[i], a[i], e[i]); end
      end
      n_checks++;
      if (done_q.size() != 2 || done_q[0] !== 64'd0) begin
         n_fail++; $display("FAIL tkeep_masked_frame: got %0d frames, first %0d, expected 2 frames, first 0", done_q.size(), (done_q.size() > 0) ? done_q[0] : 64'd0);
      end
   endtask

   task automatic test_clear();
      c5_t a, e;
      do_reset();
      build_clean(64); fdata[3] = fdata[3] ^ 32'h0000_0007; send_frame(64, 0, -1);
      wait_frames(1);
      a = get_act();
      e = get_exp();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a[i] !== e[i]) begin n_fail++; $display("FAIL clear_pre %s: got %0d expected %0d", cname[i], a[i], e[i]); end
      end
      build_clean(64); fdata[7] = fdata[7] ^ 32'h0000_0100;
      send_frame(64, 0, -1);
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      model_clear();
      repeat (2) @(posedge clk); #1;
      a = get_act();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a[i] !== 64'd0) begin n_fail++; $display("FAIL clear_collision %s: got %0d expected 0", cname[i], a[i]); end
      end
      done_q.delete();
      exp_q.delete();
      build_clean(64);
      send_frame(64, 0, 20);
      wait_frames(1);
      a = get_act();
      e = get_exp();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a[i] !== e[i]) begin n_fail++; $display("FAIL clear_straddle %s: got %0d expected %0d", cname[i], a[i], e[i]); end
      end
   endtask

   task automatic test_reset_midframe();
      c5_t a, e;
      do_reset();
      build_clean(64); fdata[0] = fdata[0] ^ 32'h1; send_frame(64, 0, -1);
      wait_frames(1);
      build_clean(64);
      for (int k = 0; k < 30; k++) begin
         tvalid = 1'b1; tdata = fdata[k]; tkeep = fkeep[k]; tlast = 1'b0;
         @(posedge clk); #1;
      end
      arst_n = 1'b0;
      #1;
      a = get_act();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a[i] !== 64'd0) begin n_fail++; $display("FAIL midreset %s: got %0d expected 0", cname[i], a[i]); end
      end
      n_checks++;
      if (tready !== 1'b0 || frame_done !== 1'b0) begin
         n_fail++; $display("FAIL midreset outputs: tready=%b frame_done=%b expected 0 0", tready, frame_done);
      end
      tvalid = 1'b0;
      @(posedge clk); #1 arst_n = 1'b1;
      @(posedge clk); #1;
      model_clear();
      done_q.delete();
      exp_q.delete();
      build_clean(64); send_frame(64, 0, -1);
      wait_frames(1);
      a = get_act();
      e = get_exp();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a[i] !== e[i]) begin n_fail++; $display("FAIL post_reset %s: got %0d expected %0d", cname[i], a[i], e[i]); end
      end
   endtask

   task automatic test_saturation();
      c5_t a, e;
      logic [3:0] s4 [5];
      do_reset();
      for (int f = 0; f < 20; f++) begin
         build_clean(63);
         for (int k = 0; k < 63; k++) fdata[k] = ~fdata[k];
         send_frame(63, 0, -1);
      end
      wait_frames(20);
      a = get_act();
      e = get_exp();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a[i] !== e[i]) begin n_fail++; $display("FAIL sat32 %s: got %0d expected %0d", cname[i], a[i], e[i]); end
      end
      s4 = '{frame_cnt4, bit_err_cnt4, err_frame_cnt4, len_err_cnt4, frame_err_bits4};
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (s4[i] !== 4'd15) begin n_fail++; $display("FAIL sat4 %s: got %0d expected 15", cname[i], s4[i]); end
      end
   endtask

   task automatic test_random();
      c5_t a, e;
      int n;
      do_reset();
      for (int f = 0; f < 12; f++) begin
         n = ($urandom_range(1, 0) == 1) ? 64 : int'($urandom_range(80, 1));
         build_clean(n);
         for (int k = 0; k < n; k++) begin
            if ($urandom_range(3, 0) == 0) fkeep[k] = 4'($urandom);
            if ($urandom_range(7, 0) == 0) fdata[k] = fdata[k] ^ 32'($urandom);
         end
         send_frame(n, 2, -1);
         repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
      end
      wait_frames(12);
      n_checks++;
      if (done_q.size() != 12) begin n_fail++; $display("FAIL random_done_count: got %0d expected 12", done_q.size()); end
      else begin
         for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (done_q[i] !== exp_q[i]) begin
               n_fail++; $display("FAIL random_frame_err_bits[%0d]: got %0d expected %0d", i, done_q[i], exp_q[i]);
            end
         end
      end
      a = get_act();
      e = get_exp();
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (a[i] !== e[i]) begin n_fail++; $display("FAIL random %s: got %0d expected %0d", cname[i], a[i], e[i]); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      init_prbs();
      test_reset();
      test_clean_frame();
      test_injected_errors();
      test_length_errors();
      test_tkeep();
      test_clear();
      test_reset_midframe();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/rx_ber_checker.md
# rx_ber_checker

Downstream consumer of the receiver's AXI-Stream output: accepts demodulated frames (32-bit words, `tlast` on the final word), compares every payload bit against a locally regenerated PRBS-15 reference, and maintains frame, bit-error, errored-frame and length-error counters for link characterisation. It sits between the receiver's `m_axi_*` port and the register or ILA readout, and never back-pressures the receiver in normal operation.

## Interface
- `WIDTH_AXI_DATA`, 32, stream data width; must be a multiple of 8.
- `LENGTH_DATA`, 1024, PAM symbols per frame.
- `PAM_ORDER`, 4, PAM order; a power of 2 in {2, 4, 8, 16}.
- `PRBS_SEED`, 15'h7FFF, LFSR seed reloaded at every frame start; must be non-zero.
- `CNT_WIDTH`, 32, width of every statistics counter.
- Derived: `WORDS_PER_FRAME = LENGTH_DATA*log2(PAM_ORDER)/WIDTH_AXI_DATA`, which is 64 at the defaults and must be an integer.

Ports:
- `clk` in 1: the only clock.
- `arst_n` in 1: reset, asynchronous and active-low.
- `s_axi_tvalid` in 1: stream beat valid.
- `s_axi_tready` out 1: stream ready.
- `s_axi_tdata` in WIDTH_AXI_DATA: payload.
- `s_axi_tkeep` in WIDTH_AXI_DATA/8: byte enables.
- `s_axi_tlast` in 1: last beat of a frame.
- `clear` in 1: synchronous one-cycle clear of all counters.
- `frame_cnt` out CNT_WIDTH: frames completed.
- `bit_err_cnt` out CNT_WIDTH: total bit errors.
- `err_frame_cnt` out CNT_WIDTH: frames with at least one bit error.
- `len_err_cnt` out CNT_WIDTH: frames whose beat count ≠ WORDS_PER_FRAME.
- `frame_err_bits` out CNT_WIDTH: bit errors in the most recent frame.
- `frame_done` out 1: one-cycle pulse when a frame's statistics are committed.

## Operation
- **Handshake.** `s_axi_tready` is a register that resets to 0 and is 1 from the first clock edge after `arst_n` deasserts. A beat is accepted when `tvalid && tready`.
- **Reference PRBS.** The 15-bit state `s` loads `PRBS_SEED` on reset and on the cycle after any accepted `tlast` beat.
  - Each output bit is `s[14]`, then `s <= {s[13:0], s[14]^s[13]}`.
  - Each accepted beat consumes WIDTH_AXI_DATA consecutive bits; `tdata[i]` is compared with the i-th bit produced for that beat (LSB first).
  - Bits in bytes with `tkeep[j]=0` are excluded from comparison. The LFSR still advances by the full word width.
- **Stage 1.** Register `err_vec = (tdata ^ ref_word) & keep_mask`, together with the `last` flag and the length-error flag.
- **Stage 2.** Popcount `err_vec` and add it into a frame accumulator that is wide enough not to overflow.
  - On a `last` beat, commit the frame: increment `frame_cnt`; add the accumulator to `bit_err_cnt`; increment `err_frame_cnt` if the frame had any errors; increment `len_err_cnt` if it had a length error.
  - Also on a `last` beat: copy the accumulator (saturated) to `frame_err_bits`, pulse `frame_done`, and zero the accumulator.
- **Frame FSM.** The FSM has two states, IDLE and RUN, with a beat counter `wcnt`.
  - IDLE → RUN on an accepted beat with `tlast=0` (`wcnt <= 1`).
  - An accepted `tlast` beat in IDLE is a one-beat frame.
  - In RUN, each accepted beat increments `wcnt`; an accepted `tlast` beat returns to IDLE.
  - Length error: `tlast` arrives with `wcnt+1 ≠ WORDS_PER_FRAME`, or a beat arrives with `wcnt ≥ WORDS_PER_FRAME` (oversize frame).
  - An oversize frame keeps comparing bits (the PRBS continues) and closes only at `tlast`. `wcnt` saturates.
- **Saturation.** All counters saturate at all-ones and never wrap. `bit_err_cnt` saturates on the add.
- **`clear`.** Zeroes the four `*_cnt` counters and `frame_err_bits`. It does not touch the FSM, PRBS, pipeline or accumulator.
  - If `clear` and a commit fall in the same cycle, `clear` wins and that frame is not counted.
  - A frame in progress during `clear` continues and is counted normally at its `tlast`.
- **Reset.** Asynchronous `arst_n` low mid-frame discards the frame.
  - FSM → IDLE, PRBS → seed, pipeline flushed.
  - All outputs return to 0: `s_axi_tready=0`, `frame_done=0`, every counter 0.

## Timing
- A beat accepted at edge T has its `err_vec` registered at T+1.
- The accumulator is updated at T+2. If the beat is `tlast`, `frame_done` is 1 in the cycle after T+2 and the counters already show the new values in that same cycle.
- Throughput is one beat per cycle with no bubbles. Back-to-back frames are allowed: the first beat of the next frame may be accepted in the cycle after `tlast`.
- Counter outputs are registered with no combinational path from the inputs.

## Test plan
- **Clean frame:** after reset, send 64 beats of the exact PRBS (seed 7FFF, `tkeep`=F, `tlast` on beat 64) → `frame_done` pulses exactly once, 2 cycles after the `tlast` handshake; `frame_cnt=1`, `bit_err_cnt=0`, `err_frame_cnt=0`, `len_err_cnt=0`.
- **Injected errors:** send three frames back-to-back; frame 2 has bits 0 and 31 of beat 10 flipped → `frame_cnt=3`, `bit_err_cnt=2`, `err_frame_cnt=1`; `frame_err_bits` reads 2 after frame 2 and 0 after frame 3.
- **Length errors:** one frame with `tlast` on beat 40 (clean PRBS) and one frame of 70 beats → `len_err_cnt=2`, `frame_cnt=2`; the PRBS reseeds after each, so a following clean 64-beat frame adds no bit errors.
- **`tkeep` masking:** beat 5 has `tkeep=4'b0011` and bytes 2–3 corrupted → `bit_err_cnt` unchanged, because masked bytes are not compared.
- **`clear` collision:** assert `clear` in the same cycle as `frame_done` → all counters 0 the next cycle and that frame is not counted; a frame straddling a `clear` is counted as `frame_cnt=1`.
- **Reset and saturation:**
  - Drop `arst_n` at beat 30 → all outputs 0 immediately, `tready=0`; after release a clean 64-beat frame gives `frame_cnt=1` with no errors.
  - With CNT_WIDTH=4, send 20 all-wrong frames → every counter holds at 15.
